// File: rtl/spec_pkg.sv
// Shared widths, the transition-table entry layout and the driver mode encoding
// for the spec state-graph driver.
package spec_pkg;
  localparam int NIN     = 2;
  localparam int NOUT    = 2;
  localparam int NSTATES = 16;
  localparam int NTRANS  = 32;

  localparam int SW = $clog2(NSTATES);
  localparam int EW = $clog2(NTRANS + 2);
  localparam int GW = $clog2(NIN + NOUT);
  localparam int AW = $clog2(NTRANS);
  localparam int KW = (NOUT > 1) ? $clog2(NOUT) : 1;

  // Signal index space: 0..NIN-1 are circuit inputs, NIN..NIN+NOUT-1 are outputs.
  typedef struct packed {
    logic          valid;
    logic [SW-1:0] from;
    logic [GW-1:0] sig;
    logic          dir;
    logic [SW-1:0] to;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  localparam logic [EW-1:0] IDLE_ENA = EW'(NTRANS);

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_VIOL = 1'b1
  } mode_e;
endpackage

// File: rtl/spec_if.sv
// Bundle between the harness (master) and the spec driver (slave): table load
// port, transition request, and the circuit-facing drive/observe signals.
interface spec_if;
  import spec_pkg::*;

  // tbl_we is a plain strobe taken on posedge only while reset is high. ena is a
  // one-cycle request with no ready: a request that cannot fire is dropped, and
  // fired pulses in the following cycle only when it was applied.
  logic              tbl_we;
  logic [AW-1:0]     tbl_addr;
  entry_t            tbl_wdata;
  logic [EW-1:0]     ena;
  logic [NIN-1:0]    inputs_o;
  logic [NOUT-1:0]   outputs_i;
  logic [SW-1:0]     state_o;
  logic              fired;
  logic              violation;
  logic [GW-1:0]     viol_sig;

  modport master (
    output tbl_we, tbl_addr, tbl_wdata, ena, outputs_i,
    input  inputs_o, state_o, fired, violation, viol_sig
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_wdata, ena, outputs_i,
    output inputs_o, state_o, fired, violation, viol_sig
  );
endinterface

// File: rtl/spec_table.sv
// Transition table: register file loaded during reset, an indexed read for the
// requested input transition and a priority scan for observed output edges.
module spec_table
  import spec_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  entry_t        tbl_wdata,
  input  logic [EW-1:0] ena,
  output entry_t        ena_entry,
  output logic          ena_in_range,
  input  logic [SW-1:0] scan_from,
  input  logic [GW-1:0] scan_sig,
  input  logic          scan_dir,
  output logic          scan_hit,
  output logic [SW-1:0] scan_to
);
  entry_t mem [NTRANS];

  // Contents deliberately have no reset so a loaded graph survives it.
  always_ff @(posedge clk) begin
    if (reset && tbl_we) begin
      mem[tbl_addr] <= tbl_wdata;
    end
  end

  always_comb begin
    ena_in_range = (ena < EW'(NTRANS));
    ena_entry    = mem[ena[AW-1:0]];
  end

  // Scan from the top so the last assignment made is the lowest matching index.
  always_comb begin
    scan_hit = 1'b0;
    scan_to  = '0;
    for (int i = NTRANS - 1; i >= 0; i--) begin
      if (mem[i].valid && (mem[i].from == scan_from) &&
          (mem[i].sig == scan_sig) && (mem[i].dir == scan_dir)) begin
        scan_hit = 1'b1;
        scan_to  = mem[i].to;
      end
    end
  end
endmodule

// File: rtl/spec_driver.sv
// Spec-graph driver: fires allowed input transitions, follows observed output
// edges through the graph and latches the first illegal output movement.
module spec_driver
  import spec_pkg::*;
#(
  parameter logic [SW-1:0]  INIT_STATE = '0,
  parameter logic [NIN-1:0] INIT_IN    = '0
) (
  input  logic   clk,
  input  logic   reset,
  spec_if.slave  bus
);
  logic [NOUT-1:0] out_q;
  logic [SW-1:0]   state_q, state_n;
  logic [NIN-1:0]  in_q, in_n;
  logic            fired_q, fired_n;
  mode_e           mode_q, mode_n;
  logic [GW-1:0]   vsig_q, vsig_n;

  logic [NOUT-1:0] delta;
  logic [KW-1:0]   low_k;
  logic [GW-1:0]   scan_sig;
  logic            scan_dir;
  logic            scan_hit;
  logic [SW-1:0]   scan_to;
  entry_t          ent;
  logic            ena_in_range;
  logic            cur_bit;
  logic            ena_ok;

  spec_table u_table (
    .clk          (clk),
    .reset        (reset),
    .tbl_we       (bus.tbl_we),
    .tbl_addr     (bus.tbl_addr),
    .tbl_wdata    (bus.tbl_wdata),
    .ena          (bus.ena),
    .ena_entry    (ent),
    .ena_in_range (ena_in_range),
    .scan_from    (state_q),
    .scan_sig     (scan_sig),
    .scan_dir     (scan_dir),
    .scan_hit     (scan_hit),
    .scan_to      (scan_to)
  );

  assign delta = bus.outputs_i ^ out_q;

  // Lowest changed output; also the reported signal when several move at once.
  always_comb begin
    low_k = '0;
    for (int k = NOUT - 1; k >= 0; k--) begin
      if (delta[k]) low_k = KW'(k);
    end
  end

  assign scan_sig = GW'(NIN) + GW'(low_k);
  assign scan_dir = bus.outputs_i[low_k];

  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (ent.sig == GW'(i)) cur_bit = in_q[i];
    end
    ena_ok = ena_in_range && ent.valid && (ent.from == state_q) &&
             (ent.sig < GW'(NIN)) && (ent.dir != cur_bit);
  end

  always_comb begin
    state_n = state_q;
    in_n    = in_q;
    fired_n = 1'b0;
    mode_n  = mode_q;
    vsig_n  = vsig_q;
    if (mode_q == MODE_RUN) begin
      if (delta != '0) begin
        if (($countones(delta) == 1) && scan_hit) begin
          state_n = scan_to;
        end else begin
          mode_n = MODE_VIOL;
          vsig_n = scan_sig;
        end
      end else if (ena_ok) begin
        for (int i = 0; i < NIN; i++) begin
          if (ent.sig == GW'(i)) in_n[i] = ent.dir;
        end
        state_n = ent.to;
        fired_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    out_q <= bus.outputs_i;
    if (reset) begin
      state_q <= INIT_STATE;
      in_q    <= INIT_IN;
      fired_q <= 1'b0;
      mode_q  <= MODE_RUN;
      vsig_q  <= '0;
    end else begin
      state_q <= state_n;
      in_q    <= in_n;
      fired_q <= fired_n;
      mode_q  <= mode_n;
      vsig_q  <= vsig_n;
    end
  end

  assign bus.state_o   = state_q;
  assign bus.inputs_o  = in_q;
  assign bus.fired     = fired_q;
  assign bus.violation = (mode_q == MODE_VIOL);
  assign bus.viol_sig  = vsig_q;
endmodule

// File: tb/tb_spec_driver.sv
// Bench for spec_driver: directed handshake-graph scenarios followed by random
// tables and output activity, compared every cycle against a graph model.
module tb_spec_driver;
  localparam int NIN    = 2;
  localparam int NOUT   = 2;
  localparam int NTRANS = 32;
  localparam int EW     = 6;
  localparam int IDLE   = NTRANS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spec_if bus ();

  spec_driver #(.INIT_STATE(4'd0), .INIT_IN(2'b00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Graph model
  bit m_valid [NTRANS];
  int m_from  [NTRANS];
  int m_sig   [NTRANS];
  int m_dir   [NTRANS];
  int m_to    [NTRANS];
  int m_state, m_in, m_fired, m_viol, m_vsig, m_prev;

  int checks = 0;
  int failures = 0;
  int outs_drv = 0;

  function automatic void model_step(bit rst, int ena, int outs);
    int changed[$];
    int sig, dir, found;
    if (rst) begin
      m_state = 0; m_in = 0; m_fired = 0; m_viol = 0; m_vsig = 0; m_prev = outs;
      return;
    end
    for (int k = 0; k < NOUT; k++)
      if (((outs >> k) & 1) != ((m_prev >> k) & 1)) changed.push_back(k);
    m_prev  = outs;
    m_fired = 0;
    if (m_viol != 0) return;
    if (changed.size() == 1) begin
      sig = NIN + changed[0];
      dir = (outs >> changed[0]) & 1;
      found = -1;
      for (int i = 0; i < NTRANS; i++)
        if (found < 0 && m_valid[i] && m_from[i] == m_state && m_sig[i] == sig && m_dir[i] == dir)
          found = i;
      if (found >= 0) m_state = m_to[found];
      else begin m_viol = 1; m_vsig = sig; end
    end else if (changed.size() > 1) begin
      m_viol = 1;
      m_vsig = NIN + changed[0];
    end else if (ena < NTRANS) begin
      if (m_valid[ena] && m_from[ena] == m_state && m_sig[ena] < NIN &&
          m_dir[ena] != ((m_in >> m_sig[ena]) & 1)) begin
        if (m_dir[ena] != 0) m_in = m_in | (1 << m_sig[ena]);
        else                 m_in = m_in & ~(1 << m_sig[ena]);
        m_state = m_to[ena];
        m_fired = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/state"},     32'(bus.state_o),   m_state);
    check({tag, "/inputs"},    32'(bus.inputs_o),  m_in);
    check({tag, "/fired"},     32'(bus.fired),     m_fired);
    check({tag, "/violation"}, 32'(bus.violation), m_viol);
    check({tag, "/viol_sig"},  32'(bus.viol_sig),  m_vsig);
  endtask

  task automatic drive_cycle(input string tag, input bit rst, input int ena, input int outs);
    @(negedge clk);
    reset         = rst;
    bus.tbl_we    = 1'b0;
    bus.ena       = ena[EW-1:0];
    bus.outputs_i = outs[NOUT-1:0];
    outs_drv      = outs;
    @(posedge clk);
    model_step(rst, ena, outs);
    #1;
    check_all(tag);
  endtask

  task automatic cycle(input string tag, input int ena, input int outs);
    drive_cycle(tag, 1'b0, ena, outs);
  endtask

  task automatic load(input int addr, input int v, input int f, input int s,
                      input int d, input int t, input bit with_reset);
    logic [11:0] w;
    w = {v[0], f[3:0], s[1:0], d[0], t[3:0]};
    @(negedge clk);
    reset         = with_reset;
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = addr[4:0];
    bus.tbl_wdata = w;
    bus.ena       = 6'(IDLE);
    bus.outputs_i = outs_drv[NOUT-1:0];
    @(posedge clk);
    if (with_reset) begin
      m_valid[addr] = (v != 0); m_from[addr] = f; m_sig[addr] = s;
      m_dir[addr] = d; m_to[addr] = t;
    end
    model_step(with_reset, IDLE, outs_drv);
    #1;
    bus.tbl_we = 1'b0;
    check_all("load");
  endtask

  initial begin
    int ena, outs, r, since_rst, viol_cycles;
    bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_wdata = '0;
    bus.ena = 6'(IDLE); bus.outputs_i = '0;

    // Handshake graph req+ ack+ req- ack-, plus a side branch and a shadowed duplicate.
    for (int i = 0; i < NTRANS; i++) begin
      case (i)
        0: load(i, 1, 0, 0, 1, 1, 1'b1);
        1: load(i, 1, 1, 2, 1, 2, 1'b1);
        2: load(i, 1, 2, 0, 0, 3, 1'b1);
        3: load(i, 1, 3, 2, 0, 0, 1'b1);
        4: load(i, 1, 1, 1, 1, 5, 1'b1);
        5: load(i, 1, 1, 2, 1, 7, 1'b1);
        default: load(i, 0, 0, 0, 0, 0, 1'b1);
      endcase
    end

    cycle("t1_req_up", 0, 0);
    cycle("t1_idle", IDLE, 0);
    cycle("t2_ack_up", IDLE, 1);
    cycle("t2_req_dn", 2, 1);
    cycle("t2_ack_dn", IDLE, 0);
    cycle("t3_not_enabled", 2, 0);
    cycle("t3_idle_plus1", NTRANS + 1, 0);
    cycle("t3_idle_max", 63, 0);
    cycle("t5_to_s1", 0, 0);
    cycle("t5_ack_beats_ena", 4, 1);
    cycle("t5_req_dn", 2, 1);
    cycle("t5_ack_dn", IDLE, 0);
    cycle("t4_bad_ack", IDLE, 1);
    cycle("t4_ena_frozen", 0, 1);
    cycle("t4_outs_sampled", IDLE, 3);
    load(0, 1, 0, 0, 1, 9, 1'b0);
    drive_cycle("t6_reset_drop_ena", 1'b1, 0, 2);
    cycle("t6_repeat_t1", 0, 2);
    cycle("t6_two_toggle", IDLE, 1);
    drive_cycle("t6_reset_mid", 1'b1, IDLE, 0);
    cycle("t6_after_reset", IDLE, 0);
    cycle("t6_bad_out1", IDLE, 2);
    drive_cycle("t6_reset2", 1'b1, IDLE, 0);

    // Random dense graphs over states 0..3.
    for (int i = 0; i < NTRANS; i++)
      load(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 3), 1'b1);
    outs = outs_drv;
    since_rst = 0;
    viol_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      ena = ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, NTRANS + 3);
      r = $urandom_range(0, 15);
      if (r == 0) outs = outs ^ 3;
      else if (r < 4) outs = outs ^ (1 << $urandom_range(0, 1));
      if (since_rst >= 40 || viol_cycles >= 5) begin
        drive_cycle("rand_reset", 1'b1, ena, outs);
        since_rst = 0;
        viol_cycles = 0;
      end else begin
        cycle("rand", ena, outs);
        since_rst++;
        if (m_viol != 0) viol_cycles++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
